// File: rtl/ser_to_par_pkg.sv
// Shared definitions for the serial-to-parallel collector.
package ser_to_par_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // COLLECT: assembling bits. STALL: output full and the next bit would complete a word.
  typedef enum logic {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } state_t;

  // Bit-counter width. It is never narrower than one bit, so WIDTH=2 still gets a real counter.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/dff_ar.sv
// Parameterised-width D register. It has an asynchronous active-low reset to zero and a load enable.
module dff_ar #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear on reset. Otherwise load d when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ser_to_par.sv
// Serial-to-parallel collector with a double-buffered output word.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// - Input side (sin_valid/sin_ready): a bit is accepted when sin_valid && sin_ready && !flush.
// - Output side (pout_valid/pout_ready): the word is taken when pout_valid && pout_ready.
// - pout and pout_valid are registered. pout does not change while pout_valid && !pout_ready.
// - sin_ready drops only when the next bit would complete a word, the output holds a word,
//   and the consumer is not taking it this cycle. It depends combinationally on pout_ready.
module ser_to_par
  import ser_to_par_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             overrun,
  output state_t           dbg_state
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_pout;
  logic             r_pout_valid;
  logic             r_overrun;
  logic [0:0]       r_state;

  logic [CW-1:0]    w_cnt_d;
  logic [WIDTH-1:0] w_shift;
  logic             w_pout_valid_d;
  logic             w_overrun_d;
  logic [0:0]       w_state_d;
  logic             w_last;
  logic             w_stall;
  logic             w_accept;
  logic             w_complete;

  // Stall term, handshake qualifiers, shifted word and next-state values.
  always_comb begin
    w_last     = (r_cnt == LAST);
    w_stall    = w_last && r_pout_valid && !pout_ready;
    w_accept   = sin_valid && !w_stall && !flush;
    w_complete = w_accept && w_last;

    if (MSB_FIRST) begin
      w_shift = {r_sreg[WIDTH-2:0], sin};
    end else begin
      w_shift = {sin, r_sreg[WIDTH-1:1]};
    end

    // A flush wins over a bit arriving in the same cycle. That bit is dropped.
    if (flush || w_complete) begin
      w_cnt_d = '0;
    end else if (w_accept) begin
      w_cnt_d = r_cnt + CW'(1);
    end else begin
      w_cnt_d = r_cnt;
    end

    // When a word completes in the same cycle as a take, pout_valid stays high with no bubble.
    if (w_complete) begin
      w_pout_valid_d = 1'b1;
    end else if (r_pout_valid && pout_ready) begin
      w_pout_valid_d = 1'b0;
    end else begin
      w_pout_valid_d = r_pout_valid;
    end

    w_overrun_d = r_overrun || (flush && (r_cnt != '0));
    w_state_d   = w_stall ? 1'(STALL) : 1'(COLLECT);
  end

  dff_ar #(.W(CW))    u_cnt   (.clk(clk), .rst_n(rst_n), .en(1'b1),       .d(w_cnt_d),        .q(r_cnt));
  dff_ar #(.W(WIDTH)) u_sreg  (.clk(clk), .rst_n(rst_n), .en(w_accept),   .d(w_shift),        .q(r_sreg));
  dff_ar #(.W(WIDTH)) u_pout  (.clk(clk), .rst_n(rst_n), .en(w_complete), .d(w_shift),        .q(r_pout));
  dff_ar #(.W(1))     u_pvld  (.clk(clk), .rst_n(rst_n), .en(1'b1),       .d(w_pout_valid_d), .q(r_pout_valid));
  dff_ar #(.W(1))     u_ovr   (.clk(clk), .rst_n(rst_n), .en(1'b1),       .d(w_overrun_d),    .q(r_overrun));
  dff_ar #(.W(1))     u_state (.clk(clk), .rst_n(rst_n), .en(1'b1),       .d(w_state_d),      .q(r_state));

  assign sin_ready  = !w_stall;
  assign pout       = r_pout;
  assign pout_valid = r_pout_valid;
  assign overrun    = r_overrun;
  assign dbg_state  = state_t'(r_state);

endmodule

// File: tb/tb_ser_to_par.sv
// Directed bench for ser_to_par. Two instances share the inputs: u_msb is MSB-first and u_lsb is LSB-first.
module tb_ser_to_par;
  import ser_to_par_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sin;
  logic       sin_valid;
  logic       flush;
  logic       pout_ready;

  logic       sin_ready_m, pout_valid_m, overrun_m;
  logic [7:0] pout_m;
  state_t     state_m;
  logic       sin_ready_l, pout_valid_l, overrun_l;
  logic [7:0] pout_l;
  state_t     state_l;

  int n_cmp = 0;
  int n_err = 0;

  // Clock generation.
  always #5 clk = ~clk;

  ser_to_par #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sin_ready(sin_ready_m),
    .flush(flush), .pout(pout_m), .pout_valid(pout_valid_m), .pout_ready(pout_ready),
    .overrun(overrun_m), .dbg_state(state_m)
  );

  ser_to_par #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sin_ready(sin_ready_l),
    .flush(flush), .pout(pout_l), .pout_valid(pout_valid_l), .pout_ready(pout_ready),
    .overrun(overrun_l), .dbg_state(state_l)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send n bits of w, starting at stream position first. Bits go out w[7] first.
  task automatic send_bits(input logic [7:0] w, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      sin       = w[7-i];
      sin_valid = 1'b1;
      step();
    end
    sin_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; flush = 1'b0; pout_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset values
    check_eq("rst_pout", 32'(pout_m), 32'h00);
    check_eq("rst_pvalid", 32'(pout_valid_m), 32'd0);
    check_eq("rst_overrun", 32'(overrun_m), 32'd0);
    check_eq("rst_sin_ready", 32'(sin_ready_m), 32'd1);

    // Basic word 1,0,1,1,0,0,1,0: MSB-first gives B2, LSB-first gives 4D
    send_bits(8'hB2, 0, 7);
    check_eq("basic_pre_valid", 32'(pout_valid_m), 32'd0);
    send_bits(8'hB2, 7, 1);
    check_eq("basic_msb_pout", 32'(pout_m), 32'hB2);
    check_eq("basic_msb_valid", 32'(pout_valid_m), 32'd1);
    check_eq("basic_lsb_pout", 32'(pout_l), 32'h4D);
    check_eq("basic_lsb_valid", 32'(pout_valid_l), 32'd1);
    step();
    check_eq("basic_valid_drop", 32'(pout_valid_m), 32'd0);
    check_eq("basic_pout_hold", 32'(pout_m), 32'hB2);

    // Backpressure: A5 is held while 3C stalls on its last bit
    pout_ready = 1'b0;
    send_bits(8'hA5, 0, 8);
    check_eq("bp_first_pout", 32'(pout_m), 32'hA5);
    check_eq("bp_first_valid", 32'(pout_valid_m), 32'd1);
    send_bits(8'h3C, 0, 7);
    sin = 1'b0; sin_valid = 1'b1;
    #1;
    check_eq("bp_sin_ready_low", 32'(sin_ready_m), 32'd0);
    step();
    check_eq("bp_state_stall", 32'(state_m), 32'(STALL));
    check_eq("bp_pout_held", 32'(pout_m), 32'hA5);
    check_eq("bp_sin_ready_still_low", 32'(sin_ready_m), 32'd0);
    pout_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(sin_ready_m), 32'd1);
    step();
    check_eq("bp_second_pout", 32'(pout_m), 32'h3C);
    check_eq("bp_second_valid", 32'(pout_valid_m), 32'd1);
    pout_ready = 1'b0; sin_valid = 1'b0;
    #1;
    check_eq("bp_state_collect", 32'(state_m), 32'(COLLECT));

    // Simultaneous take and complete: 3C switches to A5 with no valid gap
    for (int i = 0; i < 7; i++) begin
      sin = 8'hA5 >> (7 - i);
      sin_valid = 1'b1;
      step();
      check_eq("sim_hold_pout", 32'(pout_m), 32'h3C);
      check_eq("sim_hold_valid", 32'(pout_valid_m), 32'd1);
    end
    sin = 1'b1; pout_ready = 1'b1;
    #1;
    check_eq("sim_no_stall", 32'(sin_ready_m), 32'd1);
    step();
    sin_valid = 1'b0;
    check_eq("sim_pout", 32'(pout_m), 32'hA5);
    check_eq("sim_valid", 32'(pout_valid_m), 32'd1);
    check_eq("sim_state", 32'(state_m), 32'(COLLECT));

    // Flush after 5 bits, with a concurrent bit that must be dropped
    step();
    check_eq("fl_take_valid", 32'(pout_valid_m), 32'd0);
    send_bits(8'hF8, 0, 5);
    flush = 1'b1; sin = 1'b1; sin_valid = 1'b1;
    step();
    flush = 1'b0; sin_valid = 1'b0;
    check_eq("fl_overrun", 32'(overrun_m), 32'd1);
    check_eq("fl_pout", 32'(pout_m), 32'hA5);
    check_eq("fl_valid", 32'(pout_valid_m), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("fl2_overrun", 32'(overrun_m), 32'd1);
    check_eq("fl2_pout", 32'(pout_m), 32'hA5);
    check_eq("fl2_valid", 32'(pout_valid_m), 32'd0);
    send_bits(8'h96, 0, 7);
    check_eq("fl_cnt_cleared", 32'(pout_valid_m), 32'd0);
    send_bits(8'h96, 7, 1);
    check_eq("fl_next_pout", 32'(pout_m), 32'h96);
    check_eq("fl_next_valid", 32'(pout_valid_m), 32'd1);

    // Reset mid-word while a word and overrun are pending
    pout_ready = 1'b0;
    send_bits(8'hE0, 0, 3);
    rst_n = 1'b0;
    #1;
    check_eq("rmw_pout", 32'(pout_m), 32'h00);
    check_eq("rmw_valid", 32'(pout_valid_m), 32'd0);
    check_eq("rmw_overrun", 32'(overrun_m), 32'd0);
    check_eq("rmw_sin_ready", 32'(sin_ready_m), 32'd1);
    step();
    rst_n = 1'b1; pout_ready = 1'b1;
    send_bits(8'h5A, 0, 7);
    check_eq("rmw_pre_valid", 32'(pout_valid_m), 32'd0);
    send_bits(8'h5A, 7, 1);
    check_eq("rmw_clean_pout", 32'(pout_m), 32'h5A);
    check_eq("rmw_clean_valid", 32'(pout_valid_m), 32'd1);

    // A flush with an empty partial word leaves overrun clear
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("fl_empty_overrun", 32'(overrun_m), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
